// File: rtl/alu_pkg.sv
// Shared definitions for the shared add/subtract ALU and its two-port arbiter.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic ID_DP = 1'b0;
  localparam logic ID_AU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational 8-bit add/subtract with two's-complement signed-overflow flag.
module alu_addsub
  import alu_pkg::*;
(
  input  logic              i_sub,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_z,
  output logic              o_ofs
);

  logic [DATA_W-1:0] w_bEff;
  logic [DATA_W-1:0] w_carryIn;

  // Subtraction is A + ~B + 1, so one overflow rule covers both operations.
  assign w_bEff    = i_sub ? ~i_b : i_b;
  assign w_carryIn = {{(DATA_W-1){1'b0}}, i_sub};
  assign o_z       = i_a + w_bEff + w_carryIn;
  assign o_ofs     = (i_a[DATA_W-1] == w_bEff[DATA_W-1]) &&
                     (o_z[DATA_W-1] != i_a[DATA_W-1]);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one add/subtract ALU between two requesters, with a
// registered, ID-tagged response channel and a saturating overflow counter.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_z,
  output logic              rsp_ofs,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] ovf_count
);

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic              w_grant0;
  logic              w_grant1;

  logic [DATA_W-1:0] r_opA;
  logic [DATA_W-1:0] r_opB;
  logic              r_opSub;
  logic              r_opId;

  logic              r_rspValid;
  logic              r_rspId;
  logic [DATA_W-1:0] r_rspZ;
  logic              r_rspOfs;
  logic              r_rspZero;
  logic [DATA_W-1:0] r_ovfCount;

  logic [DATA_W-1:0] w_aluZ;
  logic              w_aluOfs;

  alu_addsub u_addsub (
    .i_sub (r_opSub),
    .i_a   (r_opA),
    .i_b   (r_opB),
    .o_z   (w_aluZ),
    .o_ofs (w_aluOfs)
  );

  // On a tie the requester not served last time wins; r_last resets to 1.
  always_comb begin
    w_next   = r_state;
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_valid && (!req1_valid || r_last)) begin
          w_grant0 = 1'b1;
        end else if (req1_valid) begin
          w_grant1 = 1'b1;
        end
        if (w_grant0 || w_grant1) begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: w_next = ST_DONE;
      ST_DONE: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_opA   <= '0;
      r_opB   <= '0;
      r_opSub <= 1'b0;
      r_opId  <= ID_DP;
    end else begin
      r_state <= w_next;
      if (w_grant0 || w_grant1) begin
        r_opA   <= w_grant1 ? req1_a   : req0_a;
        r_opB   <= w_grant1 ? req1_b   : req0_b;
        r_opSub <= w_grant1 ? req1_sub : req0_sub;
        r_opId  <= w_grant1 ? ID_AU    : ID_DP;
        r_last  <= w_grant1 ? ID_AU    : ID_DP;
      end
    end
  end

  // Response fields are loaded once in EXEC and then held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rspValid <= 1'b0;
      r_rspId    <= ID_DP;
      r_rspZ     <= '0;
      r_rspOfs   <= 1'b0;
      r_rspZero  <= 1'b0;
      r_ovfCount <= '0;
    end else begin
      case (r_state)
        ST_EXEC: begin
          r_rspValid <= 1'b1;
          r_rspId    <= r_opId;
          r_rspZ     <= w_aluZ;
          r_rspOfs   <= w_aluOfs;
          r_rspZero  <= (w_aluZ == '0);
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            if (r_rspOfs && (r_ovfCount != {DATA_W{1'b1}})) begin
              r_ovfCount <= r_ovfCount + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp_valid  = r_rspValid;
  assign rsp_id     = r_rspId;
  assign rsp_z      = r_rspZ;
  assign rsp_ofs    = r_rspOfs;
  assign rsp_zero   = r_rspZero;
  assign ovf_count  = r_ovfCount;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a cycle monitor with a scoreboard queue
// and a small behavioural model, driven by directed steps.
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready, req0_sub;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_sub;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_ofs, rsp_zero;
  logic [7:0] rsp_z, ovf_count;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_z      (rsp_z),
    .rsp_ofs    (rsp_ofs),
    .rsp_zero   (rsp_zero),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [7:0] z;
    logic       ofs;
    logic       zero;
  } exp_t;

  typedef enum {M_IDLE, M_EXEC, M_DONE} mstate_t;

  int      testsRun    = 0;
  int      testsFailed = 0;
  exp_t    scoreQ[$];
  int      grantLog[$];
  int      acceptCount = 0;
  int      doneCount   = 0;
  mstate_t mState      = M_IDLE;
  logic    mLast       = 1'b1;
  int      mCount      = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Signed arithmetic in full integer range: overflow means out of [-128,127].
  function automatic exp_t model(input logic id, input logic [7:0] a,
                                 input logic [7:0] b, input logic sub);
    exp_t e;
    int   sa, sb, r;
    sa     = int'($signed(a));
    sb     = int'($signed(b));
    r      = sub ? (sa - sb) : (sa + sb);
    e.id   = id;
    e.z    = r[7:0];
    e.ofs  = (r > 127) || (r < -128);
    e.zero = (r[7:0] == 8'h00);
    return e;
  endfunction

  // Cycle monitor: samples 2 ns after each falling edge, checks outputs
  // against the model and advances the model to the next cycle.
  always begin
    exp_t front;
    logic e0, e1;
    @(negedge clk);
    #2;
    if (rst) begin
      checkOutput("rstRspValid", rsp_valid, 0);
      checkOutput("rstRspId", rsp_id, 0);
      checkOutput("rstRspZ", rsp_z, 0);
      checkOutput("rstRspOfs", rsp_ofs, 0);
      checkOutput("rstRspZero", rsp_zero, 0);
      checkOutput("rstOvfCount", ovf_count, 0);
      mState = M_IDLE;
      mLast  = 1'b1;
      mCount = 0;
      scoreQ.delete();
    end else begin
      checkOutput("rspValid", rsp_valid, (mState == M_DONE));
      checkOutput("ovfCount", ovf_count, mCount);
      checkOutput("bothReady", (req0_ready && req1_ready), 0);
      if (mState == M_IDLE) begin
        e0 = req0_valid && (!req1_valid || mLast);
        e1 = req1_valid && !e0;
        checkOutput("grant0", req0_ready, e0);
        checkOutput("grant1", req1_ready, e1);
      end else begin
        checkOutput("ready0Busy", req0_ready, 0);
        checkOutput("ready1Busy", req1_ready, 0);
      end
      case (mState)
        M_IDLE: begin
          if (req0_valid && req0_ready) begin
            scoreQ.push_back(model(1'b0, req0_a, req0_b, req0_sub));
            grantLog.push_back(0);
            mLast = 1'b0;
            acceptCount++;
            mState = M_EXEC;
          end else if (req1_valid && req1_ready) begin
            scoreQ.push_back(model(1'b1, req1_a, req1_b, req1_sub));
            grantLog.push_back(1);
            mLast = 1'b1;
            acceptCount++;
            mState = M_EXEC;
          end
        end
        M_EXEC: mState = M_DONE;
        M_DONE: begin
          if (scoreQ.size() == 0) begin
            checkOutput("rspOrphan", scoreQ.size(), 1);
          end else begin
            front = scoreQ[0];
            checkOutput("rspId", rsp_id, front.id);
            checkOutput("rspZ", rsp_z, front.z);
            checkOutput("rspOfs", rsp_ofs, front.ofs);
            checkOutput("rspZero", rsp_zero, front.zero);
            if (rsp_ready) begin
              void'(scoreQ.pop_front());
              if (front.ofs && mCount < 255) mCount++;
              doneCount++;
              mState = M_IDLE;
            end
          end
        end
        default: mState = M_IDLE;
      endcase
    end
  end

  task automatic applyStimulus(input logic id, input logic [7:0] a,
                               input logic [7:0] b, input logic sub);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end
  endtask

  task automatic clearValid();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic waitAccept(input int target);
    int budget = 0;
    while (acceptCount < target && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (acceptCount < target) checkOutput("acceptTimeout", acceptCount, target);
  endtask

  task automatic waitDone(input int target);
    int budget = 0;
    while (doneCount < target && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (doneCount < target) checkOutput("doneTimeout", doneCount, target);
  endtask

  task automatic doOp(input logic id, input logic [7:0] a, input logic [7:0] b,
                      input logic sub);
    int startD = doneCount;
    applyStimulus(id, a, b, sub);
    waitAccept(acceptCount + 1);
    clearValid();
    waitDone(startD + 1);
  endtask

  initial begin
    int startG;
    int startD;
    int budget;
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Add overflow and signed-sub overflow / zero result.
    doOp(1'b0, 8'h7F, 8'h01, 1'b0);
    checkOutput("ovfAfterAdd", ovf_count, 1);
    doOp(1'b1, 8'h80, 8'h01, 1'b1);
    doOp(1'b1, 8'h55, 8'h55, 1'b1);
    checkOutput("ovfAfterSub", ovf_count, 2);

    // Round-robin from a fresh reset with both requesters always valid.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    startG = grantLog.size();
    startD = doneCount;
    applyStimulus(1'b0, 8'h10, 8'h20, 1'b0);
    applyStimulus(1'b1, 8'h05, 8'h05, 1'b1);
    budget = 0;
    while (grantLog.size() < startG + 4 && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    clearValid();
    checkOutput("rrGrantCount", grantLog.size(), startG + 4);
    waitDone(startD + 4);
    if (grantLog.size() >= startG + 4) begin
      for (int i = 0; i < 4; i++) checkOutput("rrGrant", grantLog[startG+i], i % 2);
    end

    // Backpressure: response held in DONE for several cycles.
    rsp_ready = 1'b0;
    startD = doneCount;
    applyStimulus(1'b0, 8'h40, 8'h40, 1'b0);
    applyStimulus(1'b1, 8'h01, 8'h02, 1'b0);
    waitAccept(acceptCount + 1);
    req0_valid = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("bpHoldZ", rsp_z, 8'h80);
    checkOutput("bpHoldValid", rsp_valid, 1);
    checkOutput("bpHoldReady1", req1_ready, 0);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("bpNextGrant", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    waitDone(startD + 2);

    // Reset asserted while the operation is in EXEC.
    startD = doneCount;
    applyStimulus(1'b0, 8'h7F, 8'h7F, 1'b0);
    waitAccept(acceptCount + 1);
    clearValid();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("noRspAfterRst", doneCount, startD);
    checkOutput("rspValidAfterRst", rsp_valid, 0);
    startG = grantLog.size();
    startD = doneCount;
    applyStimulus(1'b0, 8'h11, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 8'h01, 1'b0);
    waitAccept(acceptCount + 1);
    clearValid();
    waitDone(startD + 1);
    if (grantLog.size() > startG) checkOutput("tieAfterRst", grantLog[startG], 0);
    else checkOutput("tieAfterRstMissing", grantLog.size(), startG + 1);

    // Saturation of the overflow counter.
    for (int i = 0; i < 260; i++) doOp(1'b0, 8'h7F, 8'h01, 1'b0);
    checkOutput("ovfSaturated", ovf_count, 255);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
